// File: rtl/seq_restoring_divider_pkg.sv
// seq_restoring_divider_pkg: FSM states and sizing helpers for the restoring divider
package seq_restoring_divider_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic int count_width(int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// div_step: one shift/compare/subtract step of unsigned restoring division
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] shifted;
  logic fits;
  always_comb begin
    shifted = {r[WIDTH-1:0], q[WIDTH-1]};
    fits = shifted >= {1'b0, divisor};
    r_next = fits ? shifted - {1'b0, divisor} : shifted;
    q_next = {q[WIDTH-2:0], fits};
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one division in flight
import seq_restoring_divider_pkg::*;
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = count_width(WIDTH);
  state_t state, state_next;
  logic [CW-1:0] count;
  logic [WIDTH:0] r, r_next;
  logic [WIDTH-1:0] q, q_next, dvs;
  logic zero, accept, last;
  div_step #(.WIDTH(WIDTH)) u_step (
    .r(r),
    .q(q),
    .divisor(dvs),
    .r_next(r_next),
    .q_next(q_next)
  );
  assign accept = start && (state == IDLE || state == DONE);
  assign last = state == RUN && count == CW'(1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_next = IDLE;
    state_next = state == RUN ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
  end
  // A zero divisor spends a single cycle in RUN so done lands one cycle after accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      r <= '0;
      q <= '0;
      dvs <= '0;
      zero <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        q <= dividend;
        r <= '0;
        dvs <= divisor;
        zero <= divisor == '0;
        div_by_zero <= 1'b0;
        count <= divisor == '0 ? CW'(1) : CW'(WIDTH);
      end else if (state == RUN) begin
        count <= count - 1'b1;
        if (!zero) begin
          r <= r_next;
          q <= q_next;
        end
        if (last) begin
          quotient <= zero ? '1 : q_next;
          remainder <= zero ? q : r_next[WIDTH-1:0];
          div_by_zero <= zero;
        end
      end
    end
  end
endmodule
